// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI transfer scheduler.
//   state_t   : sequencer states
//   SPI_A_*   : SPI peripheral register addresses
//   norm_div  : maps a requested divisor onto the even value the SPI block uses
package spi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DIV  = 3'd1,
    WR_DATA = 3'd2,
    WAIT    = 3'd3,
    POLL    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] SPI_A_STATUS = 2'b00;
  localparam logic [1:0] SPI_A_DATA   = 2'b01;
  localparam logic [1:0] SPI_A_DIV    = 2'b10;
  localparam logic [7:0] SPI_DIV_RST  = 8'd4;

  // The SPI clock only supports even divisors >= 2: drop bit0, floor at 2.
  function automatic logic [7:0] norm_div(input logic [7:0] d);
    logic [7:0] n;
    n = d & 8'hFE;
    return (n == 8'd0) ? 8'd2 : n;
  endfunction

endpackage

// File: rtl/spi_xfer_sched_rr_arbiter.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : index with highest priority this round
//   gnt : one-hot winner (first set bit at or after ptr, wrapping)
//   any : at least one request pending
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any
);

  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/spi_xfer_sched.sv
// SPI transfer scheduler: round-robin arbitrates NREQ transmit jobs and
// runs each one on the SPI register bus (divisor write if changed, data
// write, status polling until busy clears or MAX_POLLS is exhausted).
//   clk, rst            : clock, synchronous active-high reset
//   req/req_data/req_div: per-requester job, data word, divisor
//   grant, done, err    : job ownership, completion pulse, timeout pulse
//   rd_data, busy       : captured status word, sequencer active
//   spi_*               : register bus to the single SPI peripheral
module spi_xfer_sched
  import spi_sched_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int POLL_GAP  = 4,
  parameter int MAX_POLLS = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_data,
  input  logic [NREQ*8-1:0]    req_div,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [31:0]          rd_data,
  output logic                 busy,
  output logic [31:0]          spi_wdata,
  output logic [1:0]           spi_addr,
  output logic                 spi_we,
  output logic                 spi_cs_n,
  input  logic [31:0]          spi_rdata
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PCW = $clog2(MAX_POLLS);
  localparam int GCW = $clog2(POLL_GAP + 1);

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [7:0]     last_div;
  logic [7:0]     job_div;
  logic [31:0]    job_data;
  logic [PCW-1:0] poll_cnt;
  logic [GCW-1:0] gap_cnt;

  logic [NREQ-1:0] gnt;
  logic            any;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .any (any)
  );

  // Winner's job fields and the pointer value that follows it.
  logic [31:0]   win_data;
  logic [7:0]    win_div;
  logic [PW-1:0] nxt_ptr;

  always_comb begin
    win_data = '0;
    win_div  = SPI_DIV_RST;
    nxt_ptr  = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_data = req_data[32*i +: 32];
        win_div  = norm_div(req_div[8*i +: 8]);
        nxt_ptr  = PW'((i + 1) % NREQ);
      end
    end
  end

  // Bus outputs are registered on the transition into each state so they
  // line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      last_div  <= SPI_DIV_RST;
      job_div   <= '0;
      job_data  <= '0;
      poll_cnt  <= '0;
      gap_cnt   <= '0;
      grant     <= '0;
      done      <= '0;
      err       <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_we    <= 1'b0;
      spi_addr  <= SPI_A_STATUS;
      spi_wdata <= '0;
    end else begin
      done      <= '0;
      err       <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_we    <= 1'b0;
      spi_addr  <= SPI_A_STATUS;
      spi_wdata <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            grant    <= gnt;
            job_data <= win_data;
            job_div  <= win_div;
            ptr      <= nxt_ptr;
            busy     <= 1'b1;
            spi_cs_n <= 1'b0;
            spi_we   <= 1'b1;
            if (win_div != last_div) begin
              state     <= WR_DIV;
              spi_addr  <= SPI_A_DIV;
              spi_wdata <= {24'd0, win_div};
            end else begin
              state     <= WR_DATA;
              spi_addr  <= SPI_A_DATA;
              spi_wdata <= win_data;
            end
          end
        end
        WR_DIV: begin
          last_div  <= job_div;
          state     <= WR_DATA;
          spi_cs_n  <= 1'b0;
          spi_we    <= 1'b1;
          spi_addr  <= SPI_A_DATA;
          spi_wdata <= job_data;
        end
        WR_DATA: begin
          poll_cnt <= '0;
          gap_cnt  <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (gap_cnt == GCW'(POLL_GAP - 1)) begin
            gap_cnt  <= '0;
            state    <= POLL;
            spi_cs_n <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        POLL: begin
          if (!spi_rdata[0]) begin
            rd_data <= spi_rdata;
            done    <= grant;
            state   <= DONE;
          end else if (poll_cnt == PCW'(MAX_POLLS - 1)) begin
            rd_data <= spi_rdata;
            done    <= grant;
            err     <= 1'b1;
            state   <= DONE;
          end else begin
            poll_cnt <= poll_cnt + PCW'(1);
            state    <= WAIT;
          end
        end
        DONE: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
module tb_spi_xfer_sched;

  localparam int NREQ = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ*8-1:0]  req_div;
  logic [NREQ-1:0]    grant, done;
  logic               err, busy;
  logic [31:0]        rd_data, spi_wdata, spi_rdata;
  logic [1:0]         spi_addr;
  logic               spi_we, spi_cs_n;

  always #5 clk = ~clk;

  spi_xfer_sched #(.NREQ(NREQ), .POLL_GAP(40), .MAX_POLLS(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_div(req_div),
    .grant(grant), .done(done), .err(err), .rd_data(rd_data), .busy(busy),
    .spi_wdata(spi_wdata), .spi_addr(spi_addr), .spi_we(spi_we),
    .spi_cs_n(spi_cs_n), .spi_rdata(spi_rdata)
  );

  // SPI peripheral model: busy for 32*div cycles after a data write.
  logic [7:0]  spi_div;
  logic [15:0] busy_cnt;
  logic        stuck;
  always @(posedge clk) begin
    if (rst) begin
      spi_div  <= 8'd4;
      busy_cnt <= '0;
    end else begin
      if (!spi_cs_n && spi_we && spi_addr == 2'b10) spi_div <= spi_wdata[7:0];
      if (!spi_cs_n && spi_we && spi_addr == 2'b01) busy_cnt <= 16'(32 * spi_div);
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 16'd1;
    end
  end
  assign spi_rdata = {spi_div, 23'd0, (busy_cnt != 0) | stuck};

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Observations from one job.
  logic        o_wd;
  logic [7:0]  o_wdv;
  logic [31:0] o_dat, o_rd;
  int          o_dat_cyc, o_done_cyc, o_polls;
  logic [1:0]  o_done, o_grant;
  logic        o_err, o_busy;

  task automatic run_job(input logic [1:0] r, input logic [31:0] d, input logic [7:0] dv);
    logic got;
    got = 1'b0;
    o_wd = 0; o_wdv = 0; o_dat = 0; o_rd = 0; o_dat_cyc = -1; o_done_cyc = -1;
    o_polls = 0; o_done = 0; o_grant = 0; o_err = 0; o_busy = 0;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (r[i]) begin
        req_data[32*i +: 32] = d;
        req_div[8*i +: 8]    = dv;
      end
    req = r;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!got && grant != 0) begin
        // Requester walks away and scribbles its inputs; the job must not care.
        got = 1'b1;
        o_grant = grant;
        o_busy = busy;
        req = '0;
        req_data = {NREQ{32'hBAD0BAD0}};
        req_div = {NREQ{8'h55}};
      end
      if (!spi_cs_n && spi_we && spi_addr == 2'b10) begin o_wd = 1; o_wdv = spi_wdata[7:0]; end
      if (!spi_cs_n && spi_we && spi_addr == 2'b01) begin o_dat = spi_wdata; o_dat_cyc = cyc; end
      if (!spi_cs_n && !spi_we) o_polls++;
      if (done != 0) begin
        o_done = done; o_err = err; o_rd = rd_data; o_done_cyc = cyc;
        break;
      end
    end
    if (o_done_cyc < 0) chk("job_timeout", 0, 1);
    @(negedge clk);
    chk("done_clears", {30'd0, done}, 0);
    chk("grant_clears", {30'd0, grant}, 0);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [31:0] data;
    logic [7:0]  div;
    logic        exp_wd;
    logic [7:0]  eff;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2'b01, 32'hA5A5_0F0F, 8'd4, 1'b0, 8'd4};
    vecs[1] = '{2'b10, 32'h1234_5678, 8'd7, 1'b1, 8'd6};
    vecs[2] = '{2'b10, 32'hCAFE_F00D, 8'd6, 1'b0, 8'd6};
    vecs[3] = '{2'b01, 32'h0000_FFFF, 8'd0, 1'b1, 8'd2};
    vecs[4] = '{2'b10, 32'hDEAD_BEEF, 8'd1, 1'b0, 8'd2};
    vecs[5] = '{2'b01, 32'h1357_9BDF, 8'd9, 1'b1, 8'd8};
    vecs[6] = '{2'b10, 32'h2468_ACE0, 8'd3, 1'b1, 8'd2};

    rst = 1; req = '0; req_data = '0; req_div = '0; stuck = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 0);
    chk("rst_done", {30'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_cs_n", {31'd0, spi_cs_n}, 1);
    chk("rst_we", {31'd0, spi_we}, 0);
    chk("rst_addr", {30'd0, spi_addr}, 0);
    chk("rst_wdata", spi_wdata, 0);

    // Directed jobs; last_div carries across vectors.
    for (int v = 0; v < 7; v++) begin
      run_job(vecs[v].req, vecs[v].data, vecs[v].div);
      chk($sformatf("v%0d_wr_div", v), {31'd0, o_wd}, {31'd0, vecs[v].exp_wd});
      if (vecs[v].exp_wd) chk($sformatf("v%0d_div_val", v), {24'd0, o_wdv}, {24'd0, vecs[v].eff});
      chk($sformatf("v%0d_data", v), o_dat, vecs[v].data);
      chk($sformatf("v%0d_latency", v), o_dat_cyc, vecs[v].exp_wd ? 2 : 1);
      chk($sformatf("v%0d_grant", v), {30'd0, o_grant}, {30'd0, vecs[v].req});
      chk($sformatf("v%0d_busy", v), {31'd0, o_busy}, 1);
      chk($sformatf("v%0d_done", v), {30'd0, o_done}, {30'd0, vecs[v].req});
      chk($sformatf("v%0d_err", v), {31'd0, o_err}, 0);
      chk($sformatf("v%0d_rd_data", v), o_rd, {vecs[v].eff, 23'd0, 1'b0});
      chk($sformatf("v%0d_min_dur", v), {31'd0, (o_done_cyc - o_dat_cyc) >= 32 * int'(vecs[v].eff)}, 1);
    end

    // Timeout: status never clears, exactly MAX_POLLS=8 polls.
    stuck = 1;
    run_job(2'b01, 32'h0F0F_0F0F, 8'd2);
    stuck = 0;
    chk("to_polls", o_polls, 8);
    chk("to_done", {30'd0, o_done}, 2'b01);
    chk("to_err", {31'd0, o_err}, 1);
    chk("to_rd_data", o_rd, {8'd2, 23'd0, 1'b1});

    // Arbitration from a fresh pointer with both requests held.
    @(negedge clk); rst = 1; @(negedge clk); rst = 0;
    req_data = {32'h2222_2222, 32'h1111_1111};
    req_div  = {8'd4, 8'd4};
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] expg;
      int t;
      expg = (k % 2 == 0) ? 2'b01 : 2'b10;
      t = 0;
      while (done == 0 && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) chk($sformatf("arb%0d_timeout", k), 0, 1);
      chk($sformatf("arb%0d_done", k), {30'd0, done}, {30'd0, expg});
      chk($sformatf("arb%0d_grant", k), {30'd0, grant}, {30'd0, expg});
      chk($sformatf("arb%0d_err", k), {31'd0, err}, 0);
      @(negedge clk);
      chk($sformatf("arb%0d_idle_gap", k), {31'd0, busy}, 0);
    end
    req = '0;
    @(negedge clk);

    // Reset while polling: everything returns to reset values, last_div=4.
    begin
      int t;
      req_data[63:32] = 32'h7777_7777;
      req_div[15:8] = 8'd8;
      req = 2'b10;
      t = 0;
      while (!(!spi_cs_n && spi_we && spi_addr == 2'b01) && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) chk("rstmid_timeout", 0, 1);
      repeat (5) @(negedge clk);
      chk("rstmid_busy_pre", {31'd0, busy}, 1);
      rst = 1;
      req = '0;
      @(negedge clk);
      chk("rstmid_cs_n", {31'd0, spi_cs_n}, 1);
      chk("rstmid_grant", {30'd0, grant}, 0);
      chk("rstmid_busy", {31'd0, busy}, 0);
      rst = 0;
    end
    run_job(2'b01, 32'h8888_0001, 8'd4);
    chk("post_rst_wr_div", {31'd0, o_wd}, 0);
    chk("post_rst_latency", o_dat_cyc, 1);
    chk("post_rst_data", o_dat, 32'h8888_0001);
    chk("post_rst_rd", o_rd, {8'd4, 23'd0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_xfer_sched.md
Name: spi_xfer_sched

Overview:
Sequencer and arbiter in front of the SPI peripheral's register bus.
- Accepts 32-bit transmit jobs from NREQ requesters and grants them round-robin.
- For each granted job it programs the SPI clock divisor (only if changed), writes the data word, then polls the status register until bit0 (busy) clears.
- Returns the captured status word and a one-cycle done pulse to the granted requester.
- Sits between the CPU-side/DMA-side masters and the single SPI peripheral instance; it is the peripheral's only bus master.

Parameters:
- NREQ, 2, number of requesters (2..8).
- POLL_GAP, 4, idle cycles between consecutive status polls (>=1).
- MAX_POLLS, 1024, status polls before a job is aborted with error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester job request; level, held until done.
- req_data  in  NREQ*32  per-requester transmit word; requester i uses slice [32i+31:32i].
- req_div  in  NREQ*8  per-requester SPI divisor; slice [8i+7:8i].
- grant  out  NREQ  one-hot; marks the requester owning the current job.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse coincident with done when the job timed out.
- rd_data  out  32  status word captured at completion; held until the next completion.
- busy  out  1  high whenever the FSM is not IDLE.
- spi_wdata  out  32  write data to the SPI peripheral.
- spi_addr  out  2  SPI register address: 00 status, 01 data, 10 divisor.
- spi_we  out  1  write strobe, active-high (1 = write, 0 = read).
- spi_cs_n  out  1  SPI chip select, active-low.
- spi_rdata  in  32  SPI read data; valid in the same cycle spi_cs_n=0 and spi_we=0.

Behaviour:
- Reset values:
  - grant, done, err, busy = 0; rd_data = 0.
  - spi_cs_n = 1, spi_we = 0, spi_addr = 00, spi_wdata = 0.
  - RR pointer = 0; last_div = 4, which matches the SPI reset default.
  - FSM = IDLE; poll and gap counters = 0.
- Bus default: in IDLE, WAIT and DONE, spi_cs_n=1, spi_we=0, spi_addr=00, spi_wdata=0.
- Divisor normalisation: eff_div = {req_div[7:1],1'b0}; if this is 0, eff_div = 2.
- States:
  - IDLE:
    - If any req bit is set, the RR arbiter picks the first set bit at or after the pointer, wrapping.
    - Register grant; latch the job's data and eff_div.
    - Go to WR_DIV if eff_div != last_div, else WR_DATA.
    - Pointer <= (winner+1) mod NREQ.
  - WR_DIV (1 cycle): cs_n=0, we=1, addr=10, wdata={24'b0,eff_div}. last_div <= eff_div. Go to WR_DATA.
  - WR_DATA (1 cycle): cs_n=0, we=1, addr=01, wdata=latched word. Clear poll count. Go to WAIT.
  - WAIT: count POLL_GAP cycles, then go to POLL.
  - POLL (1 cycle):
    - Drive cs_n=0, we=0, addr=00; sample spi_rdata.
    - If bit0=0: capture into rd_data, go to DONE.
    - Else if poll count has reached MAX_POLLS-1: capture, set the err flag, go to DONE.
    - Else: increment poll count, go to WAIT.
  - DONE (1 cycle): done[g]=1; err=flag. Next state is IDLE, where grant and the flag clear.
- grant is asserted from the first cycle after IDLE through the DONE cycle inclusive.
- Latency:
  - From req rising in IDLE to the data write: 1 cycle (matched divisor) or 2 cycles (new divisor).
  - A job with divisor d completes no earlier than 32*d cycles after WR_DATA.
- Boundary conditions:
  - Requester data/div changes after grant are ignored, because they are latched in IDLE.
  - A requester dropping req mid-job does not abort the job; done still pulses.
  - New requests during a job wait; no preemption.
  - Simultaneous requests are resolved by the RR pointer only.
  - Back-to-back jobs: after DONE, at least one IDLE cycle precedes the next grant.
  - rst mid-job returns everything to reset values immediately, including last_div=4. The SPI peripheral must share this reset.
- Arithmetic: poll counter is $clog2(MAX_POLLS) bits; gap counter is $clog2(POLL_GAP+1) bits; no wrap is allowed before the compare hits.

Decomposition:
- Package spi_sched_pkg holds:
  - state_t enum {IDLE, WR_DIV, WR_DATA, WAIT, POLL, DONE}.
  - Constants SPI_A_STATUS=2'b00, SPI_A_DATA=2'b01, SPI_A_DIV=2'b10, SPI_DIV_RST=8'd4.
- Sub-module rr_arbiter (parameter N; ports: req, ptr, gnt one-hot, any). It is purely combinational; the pointer register lives in spi_xfer_sched.

Test Plan:
- Single job: req[0]=1, data 32'hA5A5_0F0F, div=4 → no WR_DIV (4 == last_div). WR_DATA drives addr=01 with that data 1 cycle after req. Polls continue until the SPI clears busy, about 128 cycles later. done[0] pulses, err=0, rd_data[0]=0.
- Divisor change: req[1] with div=8'd7 → WR_DIV writes 8'h06, then WR_DATA. A second job with div=6 skips WR_DIV.
- Arbitration: req=2'b11 held continuously → grants alternate 01,10,01,10. Each done pulse goes only to the granted bit.
- Timeout: SPI model holds status bit0=1, MAX_POLLS=8 → exactly 8 POLL cycles, then done and err pulse together; rd_data bit0=1.
- Reset mid-job: assert rst during WAIT → next cycle spi_cs_n=1, grant=0, busy=0. The following job with div=4 skips WR_DIV.
- div=0 or 1 request → WR_DIV writes 8'h02.
